// File: rtl/sfx_pkg.sv
// ============================================================================
//  Module      : sfx_pkg
//  Description : Shared types, note table and sequence ROM for sfx_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sfx_pkg;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'd0,
        EVT_LOCK  = 2'd1,
        EVT_CLEAR = 2'd2,
        EVT_OVER  = 2'd3
    } evt_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        GAP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [17:0] half_period;
        logic [7:0]  dur;
        logic        last;
    } note_t;

    localparam note_t c_note_silent = '{half_period: 18'd0,      dur: 8'd1,   last: 1'b1};
    localparam note_t c_note_c5     = '{half_period: 18'd95557,  dur: 8'd40,  last: 1'b1};
    localparam note_t c_note_e5     = '{half_period: 18'd75843,  dur: 8'd60,  last: 1'b0};
    localparam note_t c_note_g5     = '{half_period: 18'd63776,  dur: 8'd60,  last: 1'b0};
    localparam note_t c_note_c6     = '{half_period: 18'd47778,  dur: 8'd60,  last: 1'b1};
    localparam note_t c_note_g4     = '{half_period: 18'd127551, dur: 8'd150, last: 1'b0};
    localparam note_t c_note_e4     = '{half_period: 18'd151686, dur: 8'd150, last: 1'b0};
    // The 300-tick C4 does not fit the 8-bit duration, so it is two 150-tick halves.
    localparam note_t c_note_c4_a   = '{half_period: 18'd191110, dur: 8'd150, last: 1'b0};
    localparam note_t c_note_c4_b   = '{half_period: 18'd191110, dur: 8'd150, last: 1'b1};

    function automatic note_t seq_rom(input evt_e evt, input logic [1:0] idx);
        note_t n;
        n = c_note_silent;
        case (evt)
            EVT_LOCK:  n = c_note_c5;
            EVT_CLEAR: begin
                case (idx)
                    2'd0:    n = c_note_e5;
                    2'd1:    n = c_note_g5;
                    default: n = c_note_c6;
                endcase
            end
            EVT_OVER: begin
                case (idx)
                    2'd0:    n = c_note_g4;
                    2'd1:    n = c_note_e4;
                    2'd2:    n = c_note_c4_a;
                    default: n = c_note_c4_b;
                endcase
            end
            default:   n = c_note_silent;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sfx_sequencer_sync_edge.sv
// ============================================================================
//  Module      : sync_edge
//  Description : Two-flop synchroniser with registered rising-edge pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_pulse
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic       r_pulse;
    logic [2:0] r_vld;

    // r_vld masks detection until r_prev holds a real sample, so a level
    // already high when reset releases is not seen as a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
            r_vld   <= 3'b000;
        end else begin
            r_meta  <= i_din;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_vld   <= {r_vld[1:0], 1'b1};
            r_pulse <= r_sync & ~r_prev & r_vld[2];
        end
    end

    assign o_pulse = r_pulse;

endmodule

`default_nettype wire

// File: rtl/sfx_sequencer.sv
// ============================================================================
//  Module      : sfx_sequencer
//  Description : Priority sound-effect scheduler driving tone half-period/enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 10
) (
    input  logic        clk,
    input  logic        reset_rtl_0,
    input  logic        evt_lock,
    input  logic        evt_clear,
    input  logic        evt_over,
    output logic [17:0] tone_half_period,
    output logic        tone_en,
    output logic        busy,
    output logic [1:0]  cur_evt
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_gap_w  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_gap_w-1:0]  c_gap_last  = c_gap_w'(GAP_TICKS - 1);

    logic                w_pls_lock;
    logic                w_pls_clear;
    logic                w_pls_over;
    logic [3:1]          r_pending;
    logic [3:1]          w_pend_nxt;
    state_e              r_state;
    evt_e                r_cur_evt;
    evt_e                w_sel;
    evt_e                w_ld_evt;
    logic [1:0]          r_idx;
    logic [1:0]          w_ld_idx;
    logic [c_tick_w-1:0] r_tick;
    logic [c_gap_w-1:0]  r_gap_cnt;
    logic [7:0]          r_dur_cnt;
    logic [7:0]          w_dur_inc;
    logic [7:0]          r_note_dur;
    logic                r_note_last;
    logic [17:0]         r_half_period;
    logic                r_tone_en;
    logic                r_busy;
    logic                w_take;
    logic                w_wrap;
    logic                w_done;
    logic                w_load;
    note_t               w_note;

    sync_edge u_sync_lock  (.clk(clk), .rst_n(reset_rtl_0), .i_din(evt_lock),  .o_pulse(w_pls_lock));
    sync_edge u_sync_clear (.clk(clk), .rst_n(reset_rtl_0), .i_din(evt_clear), .o_pulse(w_pls_clear));
    sync_edge u_sync_over  (.clk(clk), .rst_n(reset_rtl_0), .i_din(evt_over),  .o_pulse(w_pls_over));

    always_comb begin
        if (r_pending[3])      w_sel = EVT_OVER;
        else if (r_pending[2]) w_sel = EVT_CLEAR;
        else if (r_pending[1]) w_sel = EVT_LOCK;
        else                   w_sel = EVT_NONE;
    end

    // cur_evt is NONE in IDLE, so one compare covers both start and preemption.
    assign w_take    = (w_sel > r_cur_evt);
    assign w_wrap    = (r_tick == c_tick_last);
    assign w_dur_inc = r_dur_cnt + 8'd1;
    assign w_done    = (r_state == PLAY) && w_wrap && (w_dur_inc == r_note_dur);
    assign w_load    = w_take || (w_done && !r_note_last);
    assign w_ld_evt  = w_take ? w_sel : r_cur_evt;
    assign w_ld_idx  = w_take ? 2'd0 : (r_idx + 2'd1);
    assign w_note    = seq_rom(w_ld_evt, w_ld_idx);

    always_comb begin
        w_pend_nxt = r_pending;
        if (w_take) begin
            case (w_sel)
                EVT_LOCK:  w_pend_nxt[1] = 1'b0;
                EVT_CLEAR: w_pend_nxt[2] = 1'b0;
                EVT_OVER:  w_pend_nxt[3] = 1'b0;
                default:   w_pend_nxt    = r_pending;
            endcase
        end
        if (w_pls_over) w_pend_nxt[2:1] = 2'b00;
        w_pend_nxt = w_pend_nxt | {w_pls_over, w_pls_clear, w_pls_lock};
    end

    // Note outputs are registered on entry to LOAD so consecutive notes join seamlessly.
    always_ff @(posedge clk or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            r_pending     <= 3'b000;
            r_state       <= IDLE;
            r_cur_evt     <= EVT_NONE;
            r_idx         <= 2'd0;
            r_tick        <= '0;
            r_gap_cnt     <= '0;
            r_dur_cnt     <= 8'd0;
            r_note_dur    <= 8'd0;
            r_note_last   <= 1'b0;
            r_half_period <= 18'd0;
            r_tone_en     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_load) begin
                r_state       <= LOAD;
                r_cur_evt     <= w_ld_evt;
                r_idx         <= w_ld_idx;
                r_half_period <= w_note.half_period;
                r_note_dur    <= w_note.dur;
                r_note_last   <= w_note.last;
                r_tone_en     <= 1'b1;
                r_busy        <= 1'b1;
                r_tick        <= '0;
                r_dur_cnt     <= 8'd0;
            end else begin
                case (r_state)
                    IDLE: r_state <= IDLE;
                    LOAD: r_state <= PLAY;
                    PLAY: begin
                        r_tick <= w_wrap ? '0 : r_tick + 1'b1;
                        if (w_wrap) r_dur_cnt <= w_dur_inc;
                        if (w_done) begin
                            r_state       <= GAP;
                            r_tone_en     <= 1'b0;
                            r_half_period <= 18'd0;
                            r_tick        <= '0;
                            r_gap_cnt     <= '0;
                        end
                    end
                    GAP: begin
                        r_tick <= w_wrap ? '0 : r_tick + 1'b1;
                        if (w_wrap) begin
                            if (r_gap_cnt == c_gap_last) begin
                                r_state   <= IDLE;
                                r_busy    <= 1'b0;
                                r_cur_evt <= EVT_NONE;
                                r_idx     <= 2'd0;
                            end else begin
                                r_gap_cnt <= r_gap_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign tone_half_period = r_half_period;
    assign tone_en          = r_tone_en;
    assign busy             = r_busy;
    assign cur_evt          = r_cur_evt;

endmodule

`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
// ============================================================================
//  Module      : tb_sfx_sequencer
//  Description : Directed self-checking bench for sfx_sequencer (TICK_DIV=10).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sfx_sequencer;

    logic        clk = 1'b0;
    logic        reset_rtl_0;
    logic        evt_lock;
    logic        evt_clear;
    logic        evt_over;
    logic [17:0] tone_half_period;
    logic        tone_en;
    logic        busy;
    logic [1:0]  cur_evt;

    int checks   = 0;
    int failures = 0;

    sfx_sequencer #(.TICK_DIV(10), .GAP_TICKS(10)) dut (
        .clk              (clk),
        .reset_rtl_0      (reset_rtl_0),
        .evt_lock         (evt_lock),
        .evt_clear        (evt_clear),
        .evt_over         (evt_over),
        .tone_half_period (tone_half_period),
        .tone_en          (tone_en),
        .busy             (busy),
        .cur_evt          (cur_evt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until tone_half_period changes; flags any silent cycle before it.
    task automatic run_hp(output int n, output logic [17:0] nxt, output logic silent, input int limit);
        logic [17:0] cur;
        cur = tone_half_period;
        n = 0;
        silent = 1'b0;
        while (n < limit) begin
            tick(1);
            n++;
            if (tone_half_period != cur) break;
            if (!tone_en) silent = 1'b1;
        end
        nxt = tone_half_period;
    endtask

    task automatic run_until_idle(output int n, input int limit);
        n = 0;
        while (n < limit && busy) begin
            tick(1);
            n++;
        end
    endtask

    task automatic run_until_tone(output int n, input int limit);
        n = 0;
        while (n < limit && !tone_en) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset;
        reset_rtl_0 = 1'b0;
        evt_lock = 1'b0; evt_clear = 1'b0; evt_over = 1'b0;
        tick(3);
        checks++;
        if ({tone_half_period, tone_en, busy, cur_evt} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs: got hp=%0d en=%0b busy=%0b evt=%0d want all 0",
                     tone_half_period, tone_en, busy, cur_evt);
        end
        reset_rtl_0 = 1'b1;
        tick(5);
        checks++;
        if (tone_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got en=%0b busy=%0b want 0 0", tone_en, busy);
        end
    endtask

    task automatic test_lock;
        int n; logic [17:0] nxt; logic sil;
        evt_lock = 1'b1;
        tick(4);
        evt_lock = 1'b0;
        checks++;
        if (tone_en !== 1'b0) begin failures++; $display("FAIL lock_early: got en=%0b want 0", tone_en); end
        tick(1);
        checks++;
        if (tone_en !== 1'b1 || tone_half_period !== 18'd95557 || cur_evt !== 2'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL lock_start: got en=%0b hp=%0d evt=%0d busy=%0b want 1 95557 1 1",
                     tone_en, tone_half_period, cur_evt, busy);
        end
        run_hp(n, nxt, sil, 1000);
        checks++;
        if (n !== 401 || nxt !== 18'd0 || tone_en !== 1'b0) begin
            failures++;
            $display("FAIL lock_len: got cycles=%0d hp=%0d en=%0b want 401 0 0", n, nxt, tone_en);
        end
        run_until_idle(n, 500);
        checks++;
        if (n !== 100 || busy !== 1'b0 || cur_evt !== 2'd0) begin
            failures++;
            $display("FAIL lock_gap: got cycles=%0d busy=%0b evt=%0d want 100 0 0", n, busy, cur_evt);
        end
    endtask

    task automatic test_clear;
        int n; logic [17:0] nxt; logic sil;
        evt_clear = 1'b1;
        tick(4);
        evt_clear = 1'b0;
        tick(1);
        checks++;
        if (tone_half_period !== 18'd75843 || cur_evt !== 2'd2) begin
            failures++;
            $display("FAIL clear_start: got hp=%0d evt=%0d want 75843 2", tone_half_period, cur_evt);
        end
        run_hp(n, nxt, sil, 2000);
        checks++;
        if (n !== 601 || nxt !== 18'd63776 || sil !== 1'b0 || tone_en !== 1'b1) begin
            failures++;
            $display("FAIL clear_note1: got cycles=%0d hp=%0d silent=%0b want 601 63776 0", n, nxt, sil);
        end
        run_hp(n, nxt, sil, 2000);
        checks++;
        if (n !== 601 || nxt !== 18'd47778 || sil !== 1'b0 || tone_en !== 1'b1) begin
            failures++;
            $display("FAIL clear_note2: got cycles=%0d hp=%0d silent=%0b want 601 47778 0", n, nxt, sil);
        end
        run_hp(n, nxt, sil, 2000);
        checks++;
        if (n !== 601 || nxt !== 18'd0) begin
            failures++;
            $display("FAIL clear_note3: got cycles=%0d hp=%0d want 601 0", n, nxt);
        end
        run_until_idle(n, 500);
        checks++;
        if (n !== 100) begin failures++; $display("FAIL clear_gap: got cycles=%0d want 100", n); end
    endtask

    // Shared tail: full OVER sequence from its first LOAD cycle, then idle.
    task automatic check_over_seq(input string tag);
        int n; logic [17:0] nxt; logic sil;
        run_hp(n, nxt, sil, 4000);
        checks++;
        if (n !== 1501 || nxt !== 18'd151686) begin
            failures++; $display("FAIL %s_g4: got cycles=%0d hp=%0d want 1501 151686", tag, n, nxt);
        end
        run_hp(n, nxt, sil, 4000);
        checks++;
        if (n !== 1501 || nxt !== 18'd191110) begin
            failures++; $display("FAIL %s_e4: got cycles=%0d hp=%0d want 1501 191110", tag, n, nxt);
        end
        run_hp(n, nxt, sil, 8000);
        checks++;
        if (n !== 3002 || nxt !== 18'd0 || sil !== 1'b0) begin
            failures++; $display("FAIL %s_c4: got cycles=%0d hp=%0d silent=%0b want 3002 0 0", tag, n, nxt, sil);
        end
        run_until_idle(n, 500);
        checks++;
        if (n !== 100) begin failures++; $display("FAIL %s_gap: got cycles=%0d want 100", tag, n); end
        n = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (busy || tone_en) n++;
        end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL %s_no_resume: got active cycles=%0d want 0", tag, n); end
    endtask

    task automatic test_preempt;
        evt_lock = 1'b1;
        tick(4);
        evt_lock = 1'b0;
        tick(1);
        tick(95);
        evt_over = 1'b1;
        tick(4);
        checks++;
        if (tone_half_period !== 18'd95557 || cur_evt !== 2'd1) begin
            failures++;
            $display("FAIL preempt_hold: got hp=%0d evt=%0d want 95557 1", tone_half_period, cur_evt);
        end
        evt_over = 1'b0;
        tick(1);
        checks++;
        if (tone_half_period !== 18'd127551 || cur_evt !== 2'd3 || tone_en !== 1'b1) begin
            failures++;
            $display("FAIL preempt_start: got hp=%0d evt=%0d en=%0b want 127551 3 1",
                     tone_half_period, cur_evt, tone_en);
        end
        check_over_seq("preempt");
    endtask

    task automatic test_queue;
        int n; logic [17:0] nxt; logic sil;
        evt_lock = 1'b1; evt_clear = 1'b1;
        tick(4);
        evt_lock = 1'b0; evt_clear = 1'b0;
        tick(1);
        checks++;
        if (tone_half_period !== 18'd75843 || cur_evt !== 2'd2) begin
            failures++;
            $display("FAIL queue_first: got hp=%0d evt=%0d want 75843 2", tone_half_period, cur_evt);
        end
        evt_lock = 1'b1;
        tick(4);
        evt_lock = 1'b0;
        run_hp(n, nxt, sil, 2000);
        checks++;
        if (n !== 597 || nxt !== 18'd63776) begin
            failures++; $display("FAIL queue_n1: got cycles=%0d hp=%0d want 597 63776", n, nxt);
        end
        run_hp(n, nxt, sil, 2000);
        run_hp(n, nxt, sil, 2000);
        checks++;
        if (n !== 601 || nxt !== 18'd0) begin
            failures++; $display("FAIL queue_n3: got cycles=%0d hp=%0d want 601 0", n, nxt);
        end
        // GAP ticks plus the single IDLE arbitration cycle before LOAD.
        run_until_tone(n, 500);
        checks++;
        if (n !== 101 || tone_half_period !== 18'd95557 || cur_evt !== 2'd1) begin
            failures++;
            $display("FAIL queue_lock: got silent=%0d hp=%0d evt=%0d want 101 95557 1",
                     n, tone_half_period, cur_evt);
        end
        run_hp(n, nxt, sil, 1000);
        checks++;
        if (n !== 401 || nxt !== 18'd0) begin
            failures++; $display("FAIL queue_lock_len: got cycles=%0d hp=%0d want 401 0", n, nxt);
        end
        run_until_idle(n, 500);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (tone_en) n++;
        end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL queue_single_lock: got tone cycles=%0d want 0", n); end
    endtask

    task automatic test_flush;
        evt_clear = 1'b1;
        tick(4);
        evt_clear = 1'b0;
        tick(1);
        evt_lock = 1'b1;  tick(4); evt_lock = 1'b0;  tick(2);
        evt_clear = 1'b1; tick(4); evt_clear = 1'b0; tick(2);
        evt_over = 1'b1;
        tick(4);
        evt_over = 1'b0;
        tick(1);
        checks++;
        if (tone_half_period !== 18'd127551 || cur_evt !== 2'd3) begin
            failures++;
            $display("FAIL flush_start: got hp=%0d evt=%0d want 127551 3", tone_half_period, cur_evt);
        end
        check_over_seq("flush");
    endtask

    task automatic test_async_reset;
        int n;
        evt_clear = 1'b1;
        tick(5);
        checks++;
        if (tone_half_period !== 18'd75843) begin
            failures++; $display("FAIL areset_play: got hp=%0d want 75843", tone_half_period);
        end
        tick(50);
        #2;
        reset_rtl_0 = 1'b0;
        #1;
        checks++;
        if ({tone_half_period, tone_en, busy, cur_evt} !== 22'd0) begin
            failures++;
            $display("FAIL areset_now: got hp=%0d en=%0b busy=%0b evt=%0d want all 0",
                     tone_half_period, tone_en, busy, cur_evt);
        end
        tick(3);
        reset_rtl_0 = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (tone_en || busy) n++;
        end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL areset_no_retrigger: got active cycles=%0d want 0", n); end
        evt_clear = 1'b0;
        tick(3);
        evt_clear = 1'b1;
        tick(4);
        evt_clear = 1'b0;
        tick(1);
        checks++;
        if (tone_en !== 1'b1 || tone_half_period !== 18'd75843) begin
            failures++;
            $display("FAIL areset_new_edge: got en=%0b hp=%0d want 1 75843", tone_en, tone_half_period);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_clear();
        test_preempt();
        test_queue();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
- Sound-effect scheduler between the game controller and the PWM audio datapath.
- Accepts tetromino-lock, line-clear and game-over events from the frame_clk (vsync) domain, synchronises them, and arbitrates by priority.
- Steps through per-event note sequences and drives a tone half-period plus enable to the square-wave/PWM generator.
- Sits in the 100 MHz clk domain beside the audio unit.

Parameters:
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz); benches use 10.
- GAP_TICKS, 10: silent ticks inserted after each completed sequence.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_rtl_0  in  1  asynchronous, active-low reset.
- evt_lock  in  1  tetromino locked; level from vsync domain, high ≥2 clk.
- evt_clear  in  1  line cleared; same rules.
- evt_over  in  1  game over; same rules.
- tone_half_period  out  18  clk cycles per half wave of the current note; 0 when silent.
- tone_en  out  1  note playing.
- busy  out  1  FSM not in IDLE.
- cur_evt  out  2  event being played (evt_e encoding).

Behaviour:
- Reset (async assert, sync deassert by the integrator): all outputs 0, pending flags 0, sync flops 0, FSM IDLE, tick counter 0. Reset mid-note silences on the same edge.
- Input path: per input, 2-flop synchroniser then rising-edge detect on the synchronised level. An edge sets pending[evt]. One pending slot per type; repeat edges while pending are merged.
- Priority: OVER(3) > CLEAR(2) > LOCK(1). An OVER edge also clears pending LOCK and CLEAR.
- FSM states:
  - IDLE: if any pending, select the highest, go to LOAD.
  - LOAD (1 cycle): clear pending[sel]; cur_evt <= sel; fetch note[idx]; register tone_half_period and tone_en=1; reset tick and duration counters; go to PLAY.
  - PLAY: tick counter counts 0..TICK_DIV-1; each wrap increments dur_cnt. When dur_cnt == note.dur, do one of:
    - if !note.last: idx++, go to LOAD.
    - else: tone_en=0, tone_half_period=0, go to GAP.
  - GAP: silent. Counts GAP_TICKS ticks, then idx=0, cur_evt=0, go to IDLE.
- Preemption: in LOAD, PLAY or GAP, if a pending event has priority > cur_evt, set idx=0 and go to LOAD for that event. The interrupted sequence is dropped, not resumed. Equal or lower priority waits in pending.
- Simultaneous edges in the same cycle: all set pending; the highest plays first, and the rest follow in priority order, each separated by a GAP.
- Timing:
  - tone_en rises exactly 5 clk edges after the first edge sampling the input high, when the FSM is IDLE.
  - Each note lasts exactly dur*TICK_DIV cycles in PLAY plus 1 LOAD cycle.
- Widths: tick counter ceil(log2(TICK_DIV)) bits; dur_cnt 8 bits (dur 1..255, 0 illegal); idx 2 bits (max 4 notes).
- Sequences (half-period at 100 MHz, dur in ticks):
  - LOCK: C5 95557/40, last.
  - CLEAR: E5 75843/60; G5 63776/60; C6 47778/60, last.
  - OVER: G4 127551/150; E4 151686/150; C4 191110/300, last.

Decomposition:
- Package sfx_pkg holds:
  - evt_e (EVT_NONE=0, EVT_LOCK=1, EVT_CLEAR=2, EVT_OVER=3).
  - note_t struct {half_period[17:0], dur[7:0], last}.
  - note constants.
  - function seq_rom(evt_e, idx) returning note_t.
  - state_e (IDLE, LOAD, PLAY, GAP).
- Sub-module sync_edge (2-flop synchroniser plus rising-edge pulse), instantiated three times.

Test Plan (TICK_DIV=10, GAP_TICKS=10):
- Lock: reset, pulse evt_lock high 4 cycles. Required response:
  - tone_en rises 5 edges later with tone_half_period=95557 and cur_evt=1.
  - Held 401 cycles, then 0.
  - busy falls 100 cycles later.
- Clear sequence: pulse evt_clear. Required response: half-period sequence 75843→63776→47778, each 601 cycles, with no silent cycle between notes.
- Preempt: evt_lock, then evt_over 100 cycles later. Required response:
  - LOCK note cut.
  - tone_half_period=127551 and cur_evt=3 exactly 5 edges after the evt_over sample.
  - LOCK does not resume.
- Simultaneous and queue: evt_lock and evt_clear rise in the same cycle. Required response:
  - CLEAR plays fully, then 100 silent cycles, then LOCK 95557.
  - A second evt_lock during CLEAR still yields only one LOCK.
- OVER flush: evt_lock and evt_clear pending while OVER is raised. Required response: only the OVER sequence plays, then busy=0.
- Async reset: drop reset_rtl_0 mid-CLEAR, with no clk edge. Required response:
  - All outputs 0 immediately.
  - After release, no note plays without a new edge; an input held high through reset does not retrigger.
